// File: rtl/io_stage.sv
// io_stage: memory-access stage between ex and wb.
// Holds loads until the SRAM answers, aligns load data, drops stale responses.
package ex_stage_params;
  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic [31:0] alu_result;
    logic [4:0]  write_register;
    logic        register_write;
    logic        result_is_from_memory;
    logic        memory_io_unsigned;
    logic        memory_io_byte;
    logic        memory_io_halfword;
    logic        memory_io_left;
    logic        memory_io_right;
    logic [31:0] multi_use_register_data;
    logic        result_high;
    logic        result_low;
    logic        high_write;
    logic        low_write;
    logic [31:0] high_data;
    logic [31:0] low_data;
    logic        move_from_cp0;
    logic        move_to_cp0;
    logic [7:0]  cp0_address;
    logic        exception_valid;
    logic        eret_flush;
    logic [4:0]  exception_code;
    logic        is_delay_slot;
    logic [31:0] badvaddr;
  } ex_to_io_bus_t;
endpackage

package wb_stage_params;
  typedef struct packed {
    logic exception_valid;
    logic eret_flush;
  } wb_exception_bus_t;
endpackage

package io_stage_params;
  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic [4:0]  write_register;
    logic        register_write;
    logic [31:0] final_result;
    logic        result_high;
    logic        result_low;
    logic        high_write;
    logic        low_write;
    logic [31:0] high_data;
    logic [31:0] low_data;
    logic        move_from_cp0;
    logic        move_to_cp0;
    logic [7:0]  cp0_address;
    logic [31:0] multi_use_register_data;
    logic        exception_valid;
    logic        eret_flush;
    logic [4:0]  exception_code;
    logic        is_delay_slot;
    logic [31:0] badvaddr;
  } io_to_wb_bus_t;

  typedef struct packed {
    logic        valid;
    logic        data_valid;
    logic [4:0]  write_register;
    logic [31:0] write_data;
  } io_to_id_back_pass_bus_t;
endpackage

module io_stage
  import ex_stage_params::*;
  import wb_stage_params::*;
  import io_stage_params::*;
#(
  parameter int MAX_DISCARD = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wb_allow_in,
  output logic                    io_allow_in,
  input  ex_to_io_bus_t           ex_to_io_bus,
  input  logic                    ex_memory_request_accepted,
  input  logic                    data_ram_data_ok,
  input  logic [31:0]             data_ram_read_data,
  input  wb_exception_bus_t       wb_exception_bus,
  output logic                    io_have_exception_forwards,
  output io_to_wb_bus_t           io_to_wb_bus,
  output io_to_id_back_pass_bus_t io_to_id_back_pass_bus
);

  typedef enum logic {IO_IDLE, IO_WAIT} state_t;

  state_t        state;
  state_t        state_next;
  logic          io_valid;
  ex_to_io_bus_t from_ex_data;
  logic          needs_response;
  logic [31:0]   response_data;
  logic          buffered;
  logic [1:0]    discard_count;
  logic [2:0]    discard_sum;

  logic flush;
  logic new_request;
  logic capture;
  logic discard_hit;
  logic awaited_hit;
  logic io_ready_go;
  logic io_leave;

  assign flush = wb_exception_bus.exception_valid
              || wb_exception_bus.eret_flush;
  assign new_request = ex_to_io_bus.valid
                    && ex_memory_request_accepted;
  assign capture = io_allow_in && ex_to_io_bus.valid;
  assign discard_hit = data_ram_data_ok
                    && (discard_count != 2'd0);
  assign awaited_hit = (state == IO_WAIT)
                    && data_ram_data_ok
                    && (discard_count == 2'd0);
  assign io_ready_go = !needs_response
                    || buffered
                    || awaited_hit;
  assign io_allow_in = !io_valid
                    || (io_ready_go && wb_allow_in);
  assign io_leave = io_valid && io_ready_go && wb_allow_in;

  always_comb begin
    state_next = state;
    if (flush)
      state_next = IO_IDLE;
    else if (capture)
      state_next = ex_memory_request_accepted ? IO_WAIT : IO_IDLE;
    else if (awaited_hit)
      state_next = IO_IDLE;
  end

  // Responses still owed to flushed loads; a discard may coincide
  // with new debt in the same cycle.
  always_comb begin
    discard_sum = {1'b0, discard_count};
    if (flush && (state == IO_WAIT) && !awaited_hit)
      discard_sum = discard_sum + 3'd1;
    if (flush && new_request)
      discard_sum = discard_sum + 3'd1;
    if (discard_hit)
      discard_sum = discard_sum - 3'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IO_IDLE;
      io_valid       <= 1'b0;
      buffered       <= 1'b0;
      discard_count  <= 2'd0;
      needs_response <= 1'b0;
    end else begin
      assert (discard_sum <= 3'(MAX_DISCARD));
      state         <= state_next;
      discard_count <= discard_sum[1:0];
      if (flush)
        io_valid <= 1'b0;
      else if (io_allow_in)
        io_valid <= ex_to_io_bus.valid;
      if (capture && !flush)
        needs_response <= ex_memory_request_accepted;
      if (flush)
        buffered <= 1'b0;
      else if (awaited_hit && !wb_allow_in)
        buffered <= 1'b1;
      else if (io_leave)
        buffered <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (capture)
      from_ex_data <= ex_to_io_bus;
    if (awaited_hit && !wb_allow_in)
      response_data <= data_ram_read_data;
  end

  logic [31:0] r;
  logic [31:0] m;
  logic [1:0]  a;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign;
  logic [31:0] load_data;
  logic [31:0] final_result;

  always_comb begin
    r = buffered ? response_data : data_ram_read_data;
    m = from_ex_data.multi_use_register_data;
    a = from_ex_data.alu_result[1:0];
    sign = !from_ex_data.memory_io_unsigned;
    unique case (a)
      2'd0: byte_sel = r[7:0];
      2'd1: byte_sel = r[15:8];
      2'd2: byte_sel = r[23:16];
      2'd3: byte_sel = r[31:24];
    endcase
    half_sel = a[1] ? r[31:16] : r[15:0];
    load_data = r;
    unique case (1'b1)
      from_ex_data.memory_io_byte:
        load_data = {{24{sign & byte_sel[7]}}, byte_sel};
      from_ex_data.memory_io_halfword:
        load_data = {{16{sign & half_sel[15]}}, half_sel};
      from_ex_data.memory_io_left:
        unique case (a)
          2'd0: load_data = {r[7:0], m[23:0]};
          2'd1: load_data = {r[15:0], m[15:0]};
          2'd2: load_data = {r[23:0], m[7:0]};
          2'd3: load_data = r;
        endcase
      from_ex_data.memory_io_right:
        unique case (a)
          2'd0: load_data = r;
          2'd1: load_data = {m[31:24], r[31:8]};
          2'd2: load_data = {m[31:16], r[31:16]};
          2'd3: load_data = {m[31:8], r[31:24]};
        endcase
      default: load_data = r;
    endcase
    final_result = from_ex_data.result_is_from_memory
                 ? load_data : from_ex_data.alu_result;
  end

  always_comb begin
    io_to_wb_bus = '0;
    io_to_wb_bus.valid = io_valid && io_ready_go;
    io_to_wb_bus.program_count = from_ex_data.program_count;
    io_to_wb_bus.write_register = from_ex_data.write_register;
    io_to_wb_bus.register_write = from_ex_data.register_write;
    io_to_wb_bus.final_result = final_result;
    io_to_wb_bus.result_high = from_ex_data.result_high;
    io_to_wb_bus.result_low = from_ex_data.result_low;
    io_to_wb_bus.high_write = from_ex_data.high_write;
    io_to_wb_bus.low_write = from_ex_data.low_write;
    io_to_wb_bus.high_data = from_ex_data.high_data;
    io_to_wb_bus.low_data = from_ex_data.low_data;
    io_to_wb_bus.move_from_cp0 = from_ex_data.move_from_cp0;
    io_to_wb_bus.move_to_cp0 = from_ex_data.move_to_cp0;
    io_to_wb_bus.cp0_address = from_ex_data.cp0_address;
    io_to_wb_bus.multi_use_register_data =
      from_ex_data.multi_use_register_data;
    io_to_wb_bus.exception_valid = from_ex_data.exception_valid;
    io_to_wb_bus.eret_flush = from_ex_data.eret_flush;
    io_to_wb_bus.exception_code = from_ex_data.exception_code;
    io_to_wb_bus.is_delay_slot = from_ex_data.is_delay_slot;
    io_to_wb_bus.badvaddr = from_ex_data.badvaddr;
  end

  always_comb begin
    io_to_id_back_pass_bus = '0;
    io_to_id_back_pass_bus.valid = io_valid
      && from_ex_data.register_write;
    io_to_id_back_pass_bus.data_valid = io_to_id_back_pass_bus.valid
      && io_ready_go
      && !from_ex_data.result_high
      && !from_ex_data.result_low
      && !from_ex_data.move_from_cp0;
    io_to_id_back_pass_bus.write_register = from_ex_data.write_register;
    io_to_id_back_pass_bus.write_data = final_result;
  end

  assign io_have_exception_forwards = io_valid
    && (from_ex_data.exception_valid || from_ex_data.eret_flush);

  logic unused;
  assign unused = from_ex_data.valid;

endmodule

// File: doc/io_stage.md
Name: io_stage

Overview:
Memory-access pipeline stage between the execute stage and the writeback stage. It captures the execute-to-io bus and holds each load/store until the data SRAM response arrives. It aligns and sign/zero-extends load data, including the unaligned LWL/LWR merge. It then forwards the instruction to writeback and drives a back-pass bus to decode for hazard and forwarding resolution. It also tracks and discards stale SRAM responses belonging to flushed instructions.

Parameters:
MAX_DISCARD, 3, maximum number of outstanding flushed responses tracked by the discard counter (2-bit counter).

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
wb_allow_in  in  1  writeback stage can accept
io_allow_in  out  1  io stage can accept from ex
ex_to_io_bus  in  ex_stage_params::ex_to_io_bus_t  instruction from ex; valid, alu_result, memory flags, multi_use_register_data, exception fields
ex_memory_request_accepted  in  1  ex's data_ram_request && data_ram_address_ready fired for the instruction entering io this cycle
data_ram_data_ok  in  1  SRAM response valid (one per accepted request, in order)
data_ram_read_data  in  32  SRAM read data
wb_exception_bus  in  wb_stage_params::wb_exception_bus_t  exception_valid / eret_flush flush request
io_have_exception_forwards  out  1  io_valid && (exception_valid || eret_flush) of held instruction
io_to_wb_bus  out  io_stage_params::io_to_wb_bus_t  valid, program_count, write_register, register_write, final_result, plus all hi/lo, cp0, exception and badvaddr fields passed through unchanged
io_to_id_back_pass_bus  out  io_stage_params::io_to_id_back_pass_bus_t  valid, data_valid, write_register, write_data

Behaviour:
- Registers: io_valid, held bus copy (from_ex_data), state {IO_IDLE, IO_WAIT}, response buffer (32b) + buffered flag, discard_count (2b).
- Reset: io_valid=0, state=IO_IDLE, buffered=0, discard_count=0.
- Reset output values: io_to_wb_bus.valid=0, io_allow_in=1, back-pass valid=0, io_have_exception_forwards=0. Reset mid-wait drops everything, including discard_count.
- Capture: when io_allow_in, io_valid<=ex_to_io_bus.valid. The bus copy loads only when valid && io_allow_in.
- needs_response = held instruction issued an accepted memory request (latched from ex_memory_request_accepted at capture).
- State machine:
  - Capture with needs_response goes to IO_WAIT; otherwise IO_IDLE.
  - IO_WAIT -> IO_IDLE on data_ok while discard_count==0. If wb_allow_in=0 on that response, store it in the response buffer (buffered=1).
- io_ready_go = !needs_response || buffered || (state==IO_WAIT && data_ok && discard_count==0).
- io_allow_in = !io_valid || (io_ready_go && wb_allow_in).
- io_to_wb_bus.valid = io_valid && io_ready_go. buffered clears when the instruction leaves.
- Discard logic:
  - data_ok with discard_count>0 decrements the count and is ignored; it never satisfies the held instruction.
  - Discard has priority over a waiting instruction.
- Flush (exception_valid || eret_flush):
  - io_valid<=0, state<=IO_IDLE, buffered<=0.
  - If state==IO_WAIT and no data_ok this cycle, discard_count++.
  - If a new request is accepted into io in the same cycle, that request is also counted: +1, or +2 total.
  - Flush coincident with the awaited data_ok: the response is consumed, no increment.
  - discard_count reaching MAX_DISCARD and needing increment is a simulation assertion failure.
- Load data formation, using r = selected response and a = alu_result[1:0]:
  - Byte selected by a; halfword by a[1].
  - Sign-extend unless memory_io_unsigned.
  - LW: r.
  - LWL: a=0 {r[7:0],m[23:0]}; 1 {r[15:0],m[15:0]}; 2 {r[23:0],m[7:0]}; 3 r. m = multi_use_register_data.
  - LWR: a=0 r; 1 {m[31:24],r[31:8]}; 2 {m[31:16],r[31:16]}; 3 {m[31:8],r[31:24]}.
- final_result = result_is_from_memory ? load data : alu_result.
- Exceptions: a held instruction with exception_valid or eret_flush never waits; ex issued no request for it.
- Back-pass bus:
  - valid = io_valid && register_write.
  - data_valid = valid && io_ready_go && !result_high && !result_low && !move_from_cp0.
  - write_data = final_result.

Test Plan:
- lw @0x1000: accepted, data_ok +2 cycles with 0xDEADBEEF -> wb valid only in data_ok cycle, final_result=0xDEADBEEF, back-pass data_valid low while waiting.
- lb @0x1003, read 0x80123456 -> 0xFFFFFF80; lbu same -> 0x00000080; lh @0x1002 -> 0xFFFF8012.
- lwl @0x1001, m=0x11223344, read 0xAABBCCDD -> 0xCCDD3344; lwr @0x1002, same m and read -> 0x1122AABB.
- data_ok arrives while wb_allow_in=0 for 3 cycles -> response buffered, io_allow_in=0, released with correct data when wb_allow_in=1.
- flush while waiting, next load accepted; first data_ok 0x1 is discarded (count 1->0), second data_ok 0x2 delivered for the new load.
- reset asserted during IO_WAIT -> next cycle io_to_wb_bus.valid=0, io_allow_in=1, discard_count=0; non-memory addu passes with 0-cycle wait.
